// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - tick-driven LED pattern sequencer (bounce/rotate/count/blink)
//
// Ports:
//   clk_in      system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   tick_in     slow square wave, asynchronous; rising edges are counted
//   run         level: 1 advance, 0 pause (HOLD)
//   clear       level: abort to IDLE, priority over run
//   mode        00 bounce, 01 rotate-left, 10 binary count, 11 blink
//   leds        registered pattern
//   step_pulse  one-cycle strobe with every pattern step
//   wrap        one-cycle strobe when a step returns the pattern to its start value
//   busy        1 while in RUN or HOLD
module pattern_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             run,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic             step_pulse,
  output logic             wrap,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [WIDTH-1:0] START_ONE = WIDTH'(1);
  localparam logic [7:0]       DIV_LAST  = 8'(DIV - 1);

  logic             sync1_q, sync2_q, hist_q;
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;
  logic             tick_ev;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             dir_left_q, dir_left_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] nxt_leds;
  logic             nxt_dir_left;
  logic             nxt_wrap;

  // The synchronizer flops come out of reset at 0, so a tick_in level that is
  // already high at release would look like a rising edge. Events are only
  // accepted once the pipeline has filled (fill_q==2) and a genuine synchronized
  // low has been seen.
  always_comb begin
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd2) & ~sync2_q);
    tick_ev = sync2_q & ~hist_q & armed_q;
  end

  // Next pattern value for one step in the latched mode.
  always_comb begin
    nxt_leds     = leds_q;
    nxt_dir_left = dir_left_q;
    nxt_wrap     = 1'b0;
    case (mode_q)
      2'b00: begin
        if (dir_left_q) begin
          nxt_leds = leds_q << 1;
          if (nxt_leds[WIDTH-1]) nxt_dir_left = 1'b0;
        end else begin
          nxt_leds = leds_q >> 1;
          if (nxt_leds[0]) nxt_dir_left = 1'b1;
        end
        nxt_wrap = (nxt_leds == START_ONE) && nxt_dir_left;
      end
      2'b01: begin
        nxt_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
        nxt_wrap = (nxt_leds == START_ONE);
      end
      2'b10: begin
        nxt_leds = leds_q + START_ONE;
        nxt_wrap = (nxt_leds == '0);
      end
      default: begin
        nxt_leds = ~leds_q;
        nxt_wrap = (nxt_leds == '0);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    leds_d     = leds_q;
    dir_left_d = dir_left_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    if (clear) begin
      state_d    = S_IDLE;
      leds_d     = '0;
      cnt_d      = 8'd0;
      dir_left_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          leds_d = '0;
          if (run) begin
            state_d    = S_RUN;
            mode_d     = mode;
            cnt_d      = 8'd0;
            dir_left_d = 1'b1;
            leds_d     = mode[1] ? '0 : START_ONE;
          end
        end
        S_RUN: begin
          // run falling wins over a coincident tick event
          if (!run) begin
            state_d = S_HOLD;
          end else if (tick_ev) begin
            if (cnt_q == DIV_LAST) begin
              cnt_d      = 8'd0;
              leds_d     = nxt_leds;
              dir_left_d = nxt_dir_left;
              step_d     = 1'b1;
              wrap_d     = nxt_wrap;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (run) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
      fill_q     <= 2'd0;
      armed_q    <= 1'b0;
      state_q    <= S_IDLE;
      mode_q     <= 2'b00;
      cnt_q      <= 8'd0;
      leds_q     <= '0;
      dir_left_q <= 1'b1;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= tick_in;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      leds_q     <= leds_d;
      dir_left_q <= dir_left_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
    end
  end

  assign leds       = leds_q;
  assign step_pulse = step_q;
  assign wrap       = wrap_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, tick_in, run, clear;
  logic [1:0] mode;

  logic [7:0] leds4, leds1;
  logic       step4, wrap4, busy4;
  logic       step1, wrap1, busy1;

  int n_cmp  = 0;
  int n_fail = 0;

  int steps4 = 0, wraps4 = 0, lone4 = 0;
  int steps1 = 0, wraps1 = 0, lone1 = 0;
  int b_s4, b_w4, b_s1, b_w1;

  always #5 clk = ~clk;

  pattern_sequencer #(.WIDTH(8), .DIV(4)) dut4 (
    .clk_in(clk), .rst_n(rst_n), .tick_in(tick_in), .run(run), .clear(clear),
    .mode(mode), .leds(leds4), .step_pulse(step4), .wrap(wrap4), .busy(busy4)
  );

  pattern_sequencer #(.WIDTH(8), .DIV(1)) dut1 (
    .clk_in(clk), .rst_n(rst_n), .tick_in(tick_in), .run(run), .clear(clear),
    .mode(mode), .leds(leds1), .step_pulse(step1), .wrap(wrap1), .busy(busy1)
  );

  // Strobe counters; a wrap without its step_pulse is counted separately.
  always @(negedge clk) begin
    if (step4) steps4++;
    if (wrap4) wraps4++;
    if (wrap4 && !step4) lone4++;
    if (step1) steps1++;
    if (wrap1) wraps1++;
    if (wrap1 && !step1) lone1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      repeat (4) @(negedge clk);
      tick_in = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic mark();
    b_s4 = steps4; b_w4 = wraps4; b_s1 = steps1; b_w1 = wraps1;
  endtask

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; run = 1'b0; clear = 1'b0; mode = 2'b01;
    repeat (3) @(negedge clk);
    check("reset_leds",  32'(leds4), 32'h0);
    check("reset_busy",  32'(busy4), 32'h0);
    check("reset_step",  32'(step4), 32'h0);
    check("reset_wrap",  32'(wrap4), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_leds", 32'(leds4), 32'h0);

    // Rotate, DIV=4
    run = 1'b1;
    @(negedge clk);
    check("rot_start", 32'(leds4), 32'h01);
    check("rot_busy",  32'(busy4), 32'h1);
    mark();
    ticks(3);
    check("rot_3tick", 32'(leds4), 32'h01);
    ticks(1);
    check("rot_4tick", 32'(leds4), 32'h02);
    check("rot_4step", 32'(steps4 - b_s4), 32'd1);
    ticks(24);
    check("rot_28tick", 32'(leds4), 32'h80);
    check("rot_28wrap", 32'(wraps4 - b_w4), 32'd0);
    ticks(4);
    check("rot_32tick", 32'(leds4), 32'h01);
    check("rot_32step", 32'(steps4 - b_s4), 32'd8);
    check("rot_32wrap", 32'(wraps4 - b_w4), 32'd1);
    check("rot_lone",   32'(lone4), 32'd0);

    // Asynchronous reset mid-RUN
    ticks(12);
    check("rst_pre", 32'(leds4), 32'h08);
    rst_n = 1'b0;
    #1;
    check("rst_async_leds", 32'(leds4), 32'h0);
    check("rst_async_busy", 32'(busy4), 32'h0);

    // Bounce, DIV=1
    run = 1'b0; mode = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("bnc_start", 32'(leds1), 32'h01);
    mark();
    ticks(7);
    check("bnc_7", 32'(leds1), 32'h80);
    ticks(1);
    check("bnc_8", 32'(leds1), 32'h40);
    check("bnc_8wrap", 32'(wraps1 - b_w1), 32'd0);
    ticks(6);
    check("bnc_14", 32'(leds1), 32'h01);
    check("bnc_14wrap", 32'(wraps1 - b_w1), 32'd1);
    check("bnc_14step", 32'(steps1 - b_s1), 32'd14);

    // Clear, then Count, DIV=1
    clear = 1'b1;
    @(negedge clk);
    check("clr_leds", 32'(leds1), 32'h0);
    check("clr_busy", 32'(busy1), 32'h0);
    clear = 1'b0; mode = 2'b10;
    @(negedge clk);
    check("cnt_start", 32'(leds1), 32'h00);
    check("cnt_busy",  32'(busy1), 32'h1);
    mark();
    ticks(255);
    check("cnt_255", 32'(leds1), 32'hFF);
    check("cnt_255wrap", 32'(wraps1 - b_w1), 32'd0);
    ticks(1);
    check("cnt_256", 32'(leds1), 32'h00);
    check("cnt_256wrap", 32'(wraps1 - b_w1), 32'd1);
    check("cnt_256step", 32'(steps1 - b_s1), 32'd256);
    check("cnt_lone", 32'(lone1), 32'd0);

    // Hold and clear, rotate DIV=4; mode change during HOLD is ignored
    clear = 1'b1; mode = 2'b01;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("hold_start", 32'(leds4), 32'h01);
    mark();
    ticks(2);
    run = 1'b0; mode = 2'b11;
    ticks(5);
    check("hold_leds",  32'(leds4), 32'h01);
    check("hold_steps", 32'(steps4 - b_s4), 32'd0);
    check("hold_busy",  32'(busy4), 32'h1);
    run = 1'b1;
    ticks(2);
    check("hold_resume_leds",  32'(leds4), 32'h02);
    check("hold_resume_steps", 32'(steps4 - b_s4), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    check("hold_clr_leds", 32'(leds4), 32'h0);
    check("hold_clr_busy", 32'(busy4), 32'h0);

    // tick_in high through reset release
    clear = 1'b0; run = 1'b0; mode = 2'b01;
    rst_n = 1'b0; tick_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b1;
    mark();
    repeat (10) @(negedge clk);
    check("hi_rel_leds",  32'(leds1), 32'h01);
    check("hi_rel_steps", 32'(steps1 - b_s1), 32'd0);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    ticks(1);
    check("hi_rel_edge_leds",  32'(leds1), 32'h02);
    check("hi_rel_edge_steps", 32'(steps1 - b_s1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: LED pattern width in bits.
REQ-002 Parameter DIV, default 4: number of tick_in rising edges per pattern step; legal range 1..255.
REQ-003 clk_in  input  1  system clock; all state is clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick_in  input  1  slow square wave from the upstream prescaler; asynchronous to the block's sampling.
REQ-006 run  input  1  level; 1 = advance the pattern, 0 = pause.
REQ-007 clear  input  1  level; 1 = abort and return to IDLE.
REQ-008 mode  input  2  pattern select: 00 bounce, 01 rotate-left, 10 binary count, 11 blink.
REQ-009 leds  output  WIDTH  registered pattern output.
REQ-010 step_pulse  output  1  registered; high for exactly one clk_in cycle when leds changes due to a step.
REQ-011 wrap  output  1  registered; high for one cycle, coincident with step_pulse, when the pattern returns to its start value.
REQ-012 busy  output  1  registered; 1 in RUN or HOLD.

Function
REQ-013 tick_in SHALL pass through a 2-flop synchronizer plus one history flop; a tick event is synchronized=1 and history=0, one cycle wide.
REQ-014 A tick_in rising edge SHALL produce exactly one tick event, no later than 3 clk_in cycles after the edge; falling edges produce none.
REQ-015 FSM states: IDLE, RUN, HOLD.
REQ-016 IDLE -> RUN when run=1 and clear=0; on this transition mode is latched, the edge counter is set to 0, and leds loads the start value.
REQ-017 Start values: bounce 0x..01 with direction left; rotate 0x..01; count all-zeros; blink all-zeros.
REQ-018 RUN -> HOLD when run=0; HOLD -> RUN when run=1; leds, edge counter and direction are frozen in HOLD; tick events in HOLD are discarded.
REQ-019 clear=1 in any state SHALL force IDLE on the next clock, with leds=0, counter=0; clear takes priority over run.
REQ-020 In IDLE, leds SHALL be 0 and mode changes have no effect; mode changes during RUN/HOLD are ignored until the next IDLE exit.
REQ-021 In RUN, each tick event increments an 8-bit edge counter; when a tick event arrives with counter=DIV-1, the counter returns to 0 and a step occurs in that same cycle's register update.
REQ-022 Bounce step: shift toward current direction; when the shift sets the MSB, direction becomes right; when it sets bit 0, direction becomes left; period 2*(WIDTH-1) steps.
REQ-023 Rotate step: rotate left by 1; MSB wraps into bit 0; period WIDTH steps.
REQ-024 Count step: leds+1 modulo 2^WIDTH; all-ones wraps to zero; period 2^WIDTH steps.
REQ-025 Blink step: leds inverted; period 2 steps.
REQ-026 wrap SHALL assert on the step whose new leds equals the start value (and, for bounce, direction=left).
REQ-027 step_pulse and wrap update in the same clock edge as leds; latency from qualifying tick event to leds change is 1 cycle.
REQ-028 A tick event coinciding with run falling SHALL be discarded (RUN->HOLD wins); one coinciding with clear SHALL be discarded.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state IDLE, leds=0, step_pulse=0, wrap=0, busy=0, edge counter=0, direction=left, synchronizer and history flops=0.
REQ-030 After rst_n deasserts, the first tick event SHALL be recognized only from a genuine tick_in rising edge, never from a level already high at reset release.

Verification
REQ-031 Reset: assert rst_n=0 mid-RUN with leds=0x08 -> leds=0x00, busy=0 immediately, without a clock edge.
REQ-032 Rotate, DIV=4: run=1, 4 tick edges -> leds 0x01->0x02 with one step_pulse; 32 ticks total -> leds=0x01 and wrap=1 on the 8th step.
REQ-033 Bounce, DIV=1: 7 ticks -> leds=0x80; 8th tick -> 0x40; 14th tick -> 0x01 with wrap=1.
REQ-034 Count, DIV=1: 255 ticks -> 0xFF; 256th -> 0x00 with wrap=1 and step_pulse=1 in the same cycle.
REQ-035 Hold/clear: run=0 after 2 of 4 edges, 5 ticks applied, run=1, 2 more ticks -> exactly one step; then clear=1 with run=1 -> IDLE, leds=0, busy=0 next cycle.
REQ-036 tick_in held high through reset release -> no step until a low-then-high transition is applied.
